// File: rtl/dec_top_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dec_top_pipe
//  Brief    : Two-stage pipelined SEC-DED (39,32) decoder with valid/ready
//             handshakes on both sides and saturating SEC/DED event counters.
//             Stage 1 captures the codeword with its syndrome and overall
//             parity; stage 2 captures the corrected data and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module dec_top_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [38:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sec,
    output logic             out_ded,
    output logic [5:0]       out_syndrome,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);

    localparam int          c_CODE_W  = 39;
    localparam int          c_SYN_W   = 6;
    localparam logic [5:0]  c_MAX_POS = 6'd38;

    // Mask of Hamming positions 1..38 whose index has bit b_idx set.
    function automatic logic [c_CODE_W-1:0] f_syn_mask(input int b_idx);
        logic [c_CODE_W-1:0] m;
        m = '0;
        for (int k = 1; k < c_CODE_W; k++) begin
            if (((k >> b_idx) & 1) == 1) begin
                m = m | (39'd1 << k);
            end
        end
        return m;
    endfunction

    // Pull d0..d31 out of the non-power-of-two positions, ascending.
    function automatic logic [31:0] f_extract(input logic [c_CODE_W-1:0] code);
        logic [31:0] d;
        logic [4:0]  j;
        d = '0;
        j = '0;
        for (int k = 1; k < c_CODE_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                d = d | (32'(1'(code >> k)) << j);
                j = j + 5'd1;
            end
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Input-side syndrome and parity
    // ------------------------------------------------------------------
    logic [c_SYN_W-1:0] w_syn;
    logic               w_par;

    for (genvar gi = 0; gi < c_SYN_W; gi++) begin : g_syn
        assign w_syn[gi] = ^(in_code & f_syn_mask(gi));
    end

    assign w_par = ^in_code;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                r_s1_valid;
    logic [c_CODE_W-1:0] r_s1_code;
    logic [c_SYN_W-1:0]  r_s1_syn;
    logic                r_s1_par;

    logic                r_s2_valid;
    logic [31:0]         r_s2_data;
    logic                r_s2_sec;
    logic                r_s2_ded;
    logic [c_SYN_W-1:0]  r_s2_syn;

    logic [CNT_W-1:0]    r_sec_cnt;
    logic [CNT_W-1:0]    r_ded_cnt;

    // Handshake: stage 2 can take a word when empty or draining this cycle;
    // stage 1 can take a word when empty or moving into stage 2.
    logic w_s2_free;
    logic w_out_fire;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign in_ready   = !(r_s1_valid && r_s2_valid && !out_ready);
    assign w_out_fire = r_s2_valid && out_ready && !reset;

    // ------------------------------------------------------------------
    // Stage-2 classification and correction from stage-1 contents
    // ------------------------------------------------------------------
    logic                w_sec;
    logic                w_ded;
    logic [c_CODE_W-1:0] w_fix_code;
    logic [31:0]         w_fix_data;

    assign w_sec      = r_s1_par && (r_s1_syn <= c_MAX_POS);
    assign w_ded      = (!r_s1_par && (r_s1_syn != '0)) ||
                        (r_s1_par && (r_s1_syn > c_MAX_POS));
    // Syndrome 0 with odd parity flips only the overall parity bit.
    assign w_fix_code = r_s1_code ^ (w_sec ? (39'd1 << r_s1_syn) : 39'd0);
    assign w_fix_data = f_extract(w_fix_code);

    // Stage 1: capture codeword, syndrome and parity whenever it can accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_par  <= w_par;
            end
        end
    end

    // Stage 2: capture corrected data and flags; hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sec   <= 1'b0;
            r_s2_ded   <= 1'b0;
            r_s2_syn   <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_fix_data;
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
                r_s2_syn  <= r_s1_syn;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_s2_sec && (r_sec_cnt != '1)) begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
            end
            if (r_s2_ded && (r_ded_cnt != '1)) begin
                r_ded_cnt <= r_ded_cnt + 1'b1;
            end
        end
    end

    // Output valid is masked by reset so nothing transfers while it is held.
    assign out_valid    = r_s2_valid && !reset;
    assign out_data     = r_s2_data;
    assign out_sec      = r_s2_sec;
    assign out_ded      = r_s2_ded;
    assign out_syndrome = r_s2_syn;
    assign sec_count    = r_sec_cnt;
    assign ded_count    = r_ded_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dec_top_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_top_pipe
//  Brief    : Directed self-checking bench for dec_top_pipe (CNT_W=16 and a
//             CNT_W=2 instance sharing the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dec_top_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [38:0] in_code;
    logic        out_ready;
    logic        cnt_clear;

    logic        in_ready, out_valid, out_sec, out_ded;
    logic [31:0] out_data;
    logic [5:0]  out_syndrome;
    logic [15:0] sec_count, ded_count;

    logic        s_in_ready, s_out_valid, s_out_sec, s_out_ded;
    logic [31:0] s_out_data;
    logic [5:0]  s_out_syndrome;
    logic [1:0]  s_sec_count, s_ded_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dec_top_pipe #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sec(out_sec), .out_ded(out_ded),
        .out_syndrome(out_syndrome), .cnt_clear(cnt_clear),
        .sec_count(sec_count), .ded_count(ded_count)
    );

    dec_top_pipe #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_code(in_code), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_sec(s_out_sec), .out_ded(s_out_ded),
        .out_syndrome(s_out_syndrome), .cnt_clear(cnt_clear),
        .sec_count(s_sec_count), .ded_count(s_ded_count)
    );

    // Reference encoder: data into non-power-of-two positions, check bits
    // at 1,2,4,8,16,32, overall even parity at bit 0.
    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [38:0] c;
        int          j;
        logic        b;
        c = '0;
        j = 0;
        for (int k = 1; k < 39; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = d[j];
                j++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            b = 1'b0;
            for (int k = 1; k < 39; k++) begin
                if ((((k >> i) & 1) == 1) && (k != (1 << i))) b = b ^ c[k];
            end
            c[1 << i] = b;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word through an unstalled pipe: visible two edges after capture.
    task automatic push_check(input logic [38:0] code, input logic [31:0] d,
                              input logic sec, input logic ded,
                              input logic [5:0] syn, input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = code;
        tick();
        in_valid  = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_data"},  64'(out_data), 64'(d));
        chk({tag, "_sec"},   64'(out_sec), 64'(sec));
        chk({tag, "_ded"},   64'(out_ded), 64'(ded));
        chk({tag, "_syn"},   64'(out_syndrome), 64'(syn));
        tick();
        chk({tag, "_drained"}, 64'(out_valid), 64'(0));
    endtask

    logic [31:0] words [10] = '{32'd1979398776, 32'd1010226197, 32'hDEADBEEF,
                                32'h00000000, 32'hFFFFFFFF, 32'h12345678,
                                32'h80000001, 32'hA5A5A5A5, 32'h5A5A5A5A,
                                32'h0F0F0F0F};

    initial begin
        int          sent, recv, cyc;
        logic        stalled;
        logic [31:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data), 64'(0));
        chk("rst_flags",     64'({out_sec, out_ded}), 64'(0));
        chk("rst_syn",       64'(out_syndrome), 64'(0));
        chk("rst_counts",    64'({sec_count, ded_count}), 64'(0));
        chk("rst_in_ready",  64'(in_ready), 64'(1));

        // Directed vectors
        push_check(39'h0,  32'h0, 1'b0, 1'b0, 6'd0, "zero");
        push_check(39'hF,  32'h1, 1'b0, 1'b0, 6'd0, "data1");
        push_check(39'h2F, 32'h1, 1'b1, 1'b0, 6'd5, "flip5");
        chk("sec_count_1", 64'(sec_count), 64'(1));
        push_check(39'h1,  32'h0, 1'b1, 1'b0, 6'd0, "flip0");
        chk("sec_count_2", 64'(sec_count), 64'(2));
        push_check(39'h6,  32'h0, 1'b0, 1'b1, 6'd3, "double");
        chk("ded_count_1", 64'(ded_count), 64'(1));
        // Odd parity with syndrome 63 (beyond position 38): uncorrectable,
        // data bit d25 (position 31) passes through uncorrected.
        push_check(39'h1_8000_0001, 32'h0200_0000, 1'b0, 1'b1, 6'd63, "synhigh");
        chk("ded_count_2", 64'(ded_count), 64'(2));

        // Streaming with random backpressure
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (recv < 10 && cyc < 300) begin
            in_valid  = (sent < 10);
            in_code   = (sent < 10) ? enc(words[sent]) : 39'h0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("stream_in_ready", 64'(in_ready),
                64'(!(((sent - recv) == 2) && !out_ready)));
            if (stalled) begin
                chk("stream_hold_valid", 64'(out_valid), 64'(1));
                chk("stream_hold_data",  64'(out_data), 64'(held));
            end
            if (out_valid && out_ready) begin
                chk("stream_data",  64'(out_data), 64'(words[recv]));
                chk("stream_flags", 64'({out_sec, out_ded}), 64'(0));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick();
            cyc++;
        end
        chk("stream_count", 64'(recv), 64'(10));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stream_empty", 64'(out_valid), 64'(0));

        // Saturation on the 2-bit counter instance
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clr_s_counts", 64'({s_sec_count, s_ded_count}), 64'(0));
        chk("clr_counts",   64'({sec_count, ded_count}), 64'(0));
        repeat (5) push_check(39'h2F, 32'h1, 1'b1, 1'b0, 6'd5, "sat");
        chk("sat_s_sec", 64'(s_sec_count), 64'(3));
        chk("sat_sec",   64'(sec_count), 64'(5));

        // Clear coinciding with a SEC output transfer
        in_valid = 1'b1;
        in_code  = 39'h2F;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_inc_valid", 64'(out_valid & out_sec), 64'(1));
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clr_inc_sec",   64'(sec_count), 64'(0));
        chk("clr_inc_s_sec", 64'(s_sec_count), 64'(0));

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 39'h2F;
        tick();
        in_code   = enc(32'h12345678);
        tick();
        in_valid  = 1'b0;
        chk("full_valid",    64'(out_valid), 64'(1));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b1;
        tick();
        chk("midrst_valid", 64'(out_valid), 64'(0));
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_stale", 64'(out_valid), 64'(0));
        end
        chk("midrst_counts",   64'({sec_count, ded_count}), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
